gate_sequencer: RTL
===================

Name: gate_sequencer

Overview:
Step sequencer that drives the gate/pitch inputs of the waveform generator bank (GateOpen, GateClose, Incr). It replaces hard-coded gate stimulus with a programmable table of notes, each with a pitch increment, an on-time and an off-time. It plays the table in order and loops. It sits between a host/load interface and the WaveGen instances.

Parameters:
WAVE_DEPTH, 8, width of Incr (phase increment) fed to WaveGen
NUM_STEPS, 8, number of table entries (power of two)
STEP_ADDR_BITS, 3, log2(NUM_STEPS)
DUR_BITS, 8, width of on/off duration fields

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset (sampled on rising Clock; 0 = reset)
Run  in  1  level; 1 = play sequence, 0 = stop after current note
Load  in  1  table write strobe, one entry per cycle
LoadAddr  in  STEP_ADDR_BITS  entry index to write
LoadIncr  in  WAVE_DEPTH  pitch increment for entry
LoadOn  in  DUR_BITS  on-time field
LoadOff  in  DUR_BITS  off-time field
LoadLast  in  1  entry marks end of sequence (wrap to 0 after it)
GateOpen  out  1  one-cycle note-on pulse
GateClose  out  1  one-cycle note-off pulse
Incr  out  WAVE_DEPTH  pitch increment of current/last note
Step  out  STEP_ADDR_BITS  index of current note
Busy  out  1  1 whenever FSM not IDLE

Behaviour:
- Reset (Reset==0 at a rising edge): FSM=IDLE; GateOpen=0, GateClose=0, Incr=0, Step=0, Busy=0; all table entries cleared to {Incr 0, On 0, Off 0, Last 0}. Reset takes priority over Load and Run, including mid-note; no GateClose is emitted for an interrupted note.
- All outputs registered. States: IDLE, OPEN, HOLD, CLOSE, REST.
- IDLE: Run==1 sampled at edge N -> OPEN visible at N+1.
- OPEN (1 cycle): GateOpen=1; Incr, on-count, off-count, last-flag latched from table[Step] in this same cycle. Next state: HOLD if On>0, else CLOSE.
- HOLD: counts down the latched On value. GateClose asserts exactly On+1 cycles after GateOpen (On=0 -> next cycle; On=255 -> 256 cycles).
- CLOSE (1 cycle): GateClose=1. Step advances on this edge: Step <= 0 if latched Last==1 or Step==NUM_STEPS-1, else Step+1. If Run==0 -> IDLE with Step <= 0; else REST if Off>0, else OPEN.
- REST: next GateOpen exactly Off+1 cycles after GateClose. Run==0 sampled in REST -> IDLE next cycle, Step <= 0, no further pulses.
- Run==0 during OPEN/HOLD: note completes normally (GateClose still emitted at its scheduled cycle), then IDLE. A gate is never left open by Run.
- GateOpen and GateClose are never asserted in the same cycle; every GateOpen is followed by exactly one GateClose unless reset intervenes.
- Load: writes table[LoadAddr] at the edge, any state. The table entry is read only in OPEN: a write to the playing entry after its OPEN affects only its next play. A write in the same cycle as OPEN reads the old contents (read-before-write).
- Incr holds its value through IDLE/REST (WaveGen keeps its last pitch); it changes only in OPEN or on reset.
- Busy = (state != IDLE).
- Durations are unsigned; no saturation needed, counters sized DUR_BITS.

Test Plan:
- Reset: Reset=0 for 2 cycles with Run=1, Load=1 -> all outputs 0, no pulse; first GateOpen occurs 1 cycle after first edge with Reset=1 and Run=1.
- Single note: entry0={Incr 0x0F, On 3, Off 2, Last 1}, Run=1 -> GateOpen cycle t, Incr=0x0F at t; GateClose at t+4; next GateOpen at t+7; Step stays 0.
- Loop/wrap: entries 0..7 with On=0, Off=0, Last=0, Incr=k+1 -> Step cycles 0..7,0; GateOpen every 2 cycles; Incr sequence 1..8,1.
- Stop mid-note: Run drops 1 cycle after GateOpen with On=10 -> GateClose still at t+11, then Busy=0, Step=0, no further GateOpen.
- Live edit: write entry0 Incr=0x20 during its HOLD -> current Incr stays 0x0F; next play of entry0 shows 0x20.
- Reset mid-HOLD: Reset=0 while gate open -> next cycle outputs 0, Busy=0, GateClose never emitted, table cleared.

Source files
------------

// File: rtl/gate_sequencer_if.sv
// Host/load and WaveGen-facing signal bundle for the gate sequencer.
// The master side is the host that writes the note table and controls Run.
// The slave side is the sequencer, which drives the gate pulses and pitch.
interface gate_sequencer_if #(
    parameter int WAVE_DEPTH     = 8,
    parameter int STEP_ADDR_BITS = 3,
    parameter int DUR_BITS       = 8
);
    // Host control and table load port
    logic                      Run;
    logic                      Load;
    logic [STEP_ADDR_BITS-1:0] LoadAddr;
    logic [WAVE_DEPTH-1:0]     LoadIncr;
    logic [DUR_BITS-1:0]       LoadOn;
    logic [DUR_BITS-1:0]       LoadOff;
    logic                      LoadLast;

    // Gate/pitch outputs toward the WaveGen bank plus status
    logic                      GateOpen;
    logic                      GateClose;
    logic [WAVE_DEPTH-1:0]     Incr;
    logic [STEP_ADDR_BITS-1:0] Step;
    logic                      Busy;

    modport master (
        output Run, Load, LoadAddr, LoadIncr, LoadOn, LoadOff, LoadLast,
        input  GateOpen, GateClose, Incr, Step, Busy
    );

    modport slave (
        input  Run, Load, LoadAddr, LoadIncr, LoadOn, LoadOff, LoadLast,
        output GateOpen, GateClose, Incr, Step, Busy
    );
endinterface

// File: rtl/gate_sequencer.sv
// Programmable gate/pitch step sequencer.
// Plays a table of notes (pitch increment, on-time, off-time, last flag) in
// order, looping, and emits one-cycle GateOpen/GateClose pulses for WaveGen.
// All outputs are registered: they are decoded from the next state and
// loaded on the same edge the FSM moves, so they line up with the state.
module gate_sequencer #(
    parameter int WAVE_DEPTH     = 8,
    parameter int NUM_STEPS      = 8,
    parameter int STEP_ADDR_BITS = 3,
    parameter int DUR_BITS       = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    gate_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OPEN  = 3'd1,
        S_HOLD  = 3'd2,
        S_CLOSE = 3'd3,
        S_REST  = 3'd4
    } state_t;

    typedef struct packed {
        logic [WAVE_DEPTH-1:0] incr;
        logic [DUR_BITS-1:0]   on_len;
        logic [DUR_BITS-1:0]   off_len;
        logic                  last;
    } entry_t;

    localparam logic [STEP_ADDR_BITS-1:0] STEP_ZERO = STEP_ADDR_BITS'(0);
    localparam logic [STEP_ADDR_BITS-1:0] STEP_ONE  = STEP_ADDR_BITS'(1);
    localparam logic [STEP_ADDR_BITS-1:0] STEP_MAX  = STEP_ADDR_BITS'(NUM_STEPS - 1);
    localparam logic [DUR_BITS-1:0]       DUR_ZERO  = DUR_BITS'(0);
    localparam logic [DUR_BITS-1:0]       DUR_ONE   = DUR_BITS'(1);

    // Note table
    entry_t                    tbl_q [NUM_STEPS];

    // FSM and sequencing state
    state_t                    state_q, state_d;
    logic [STEP_ADDR_BITS-1:0] step_q, step_d;
    logic [DUR_BITS-1:0]       cnt_q, cnt_d;

    // Fields of the note currently playing, captured when it opens
    logic [WAVE_DEPTH-1:0]     incr_q, incr_d;
    logic [DUR_BITS-1:0]       on_len_q, on_len_d;
    logic [DUR_BITS-1:0]       off_len_q, off_len_d;
    logic                      last_q, last_d;

    // Registered pulse/status outputs
    logic                      gate_open_q, gate_open_d;
    logic                      gate_close_q, gate_close_d;
    logic                      busy_q, busy_d;

    entry_t                    rd_entry_s;

    // Next-state logic: note timing, step advance and Run handling
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Run) begin
                    state_d = S_OPEN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OPEN: begin
                // Run is ignored until the note has closed
                if (on_len_q != DUR_ZERO) begin
                    state_d = S_HOLD;
                    cnt_d   = on_len_q;
                end else begin
                    state_d = S_CLOSE;
                end
            end
            S_HOLD: begin
                // cnt_q counts On..1, so HOLD lasts exactly On cycles
                if (cnt_q == DUR_ONE) begin
                    state_d = S_CLOSE;
                end else begin
                    cnt_d = cnt_q - DUR_ONE;
                end
            end
            S_CLOSE: begin
                if (last_q || (step_q == STEP_MAX)) begin
                    step_d = STEP_ZERO;
                end else begin
                    step_d = step_q + STEP_ONE;
                end
                if (!bus.Run) begin
                    state_d = S_IDLE;
                    step_d  = STEP_ZERO;
                end else if (off_len_q != DUR_ZERO) begin
                    state_d = S_REST;
                    cnt_d   = off_len_q;
                end else begin
                    state_d = S_OPEN;
                end
            end
            S_REST: begin
                if (!bus.Run) begin
                    state_d = S_IDLE;
                    step_d  = STEP_ZERO;
                end else if (cnt_q == DUR_ONE) begin
                    state_d = S_OPEN;
                end else begin
                    cnt_d = cnt_q - DUR_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = STEP_ZERO;
                cnt_d   = DUR_ZERO;
            end
        endcase
    end

    // Capture the entry for the note about to open; table read happens before any same-edge write
    always_comb begin
        rd_entry_s = tbl_q[step_d];
        if (state_d == S_OPEN) begin
            incr_d    = rd_entry_s.incr;
            on_len_d  = rd_entry_s.on_len;
            off_len_d = rd_entry_s.off_len;
            last_d    = rd_entry_s.last;
        end else begin
            incr_d    = incr_q;
            on_len_d  = on_len_q;
            off_len_d = off_len_q;
            last_d    = last_q;
        end
    end

    // Output decode from the next state, so the registered pulses coincide with OPEN/CLOSE
    always_comb begin
        gate_open_d  = (state_d == S_OPEN);
        gate_close_d = (state_d == S_CLOSE);
        busy_d       = (state_d != S_IDLE);
    end

    // FSM, counters, captured note fields and outputs
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q      <= S_IDLE;
            step_q       <= STEP_ZERO;
            cnt_q        <= DUR_ZERO;
            incr_q       <= '0;
            on_len_q     <= DUR_ZERO;
            off_len_q    <= DUR_ZERO;
            last_q       <= 1'b0;
            gate_open_q  <= 1'b0;
            gate_close_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            incr_q       <= incr_d;
            on_len_q     <= on_len_d;
            off_len_q    <= off_len_d;
            last_q       <= last_d;
            gate_open_q  <= gate_open_d;
            gate_close_q <= gate_close_d;
            busy_q       <= busy_d;
        end
    end

    // Note table: cleared on reset, one host write per cycle in any state
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (bus.Load) begin
            tbl_q[bus.LoadAddr] <= {bus.LoadIncr, bus.LoadOn, bus.LoadOff, bus.LoadLast};
        end
    end

    assign bus.GateOpen  = gate_open_q;
    assign bus.GateClose = gate_close_q;
    assign bus.Incr      = incr_q;
    assign bus.Step      = step_q;
    assign bus.Busy      = busy_q;

endmodule
